// File: rtl/pipe_rate_change_if.sv
// PIPE rate-change bundle between the LTSSM/PHY side and the MAC-side sequencer.
// master is the sequencer view; slave is the LTSSM/PHY view.
interface pipe_rate_change_if #(
    parameter int LANESNUMBER = 16
);
    logic                   req;
    logic [3:0]             req_rate;
    logic [4:0]             req_pclk_rate;
    logic [1:0]             req_width;
    logic [LANESNUMBER-1:0] active_lanes;
    logic                   PclkChangeOk;
    logic [LANESNUMBER-1:0] PhyStatus;
    logic [3:0]             Rate;
    logic [4:0]             PCLKRate;
    logic [1:0]             width;
    logic                   PclkChangeAck;
    logic                   busy;
    logic                   tx_hold;
    logic                   done;
    logic                   timeout;

    modport master (
        input  req, req_rate, req_pclk_rate, req_width, active_lanes,
        input  PclkChangeOk, PhyStatus,
        output Rate, PCLKRate, width, PclkChangeAck, busy, tx_hold, done, timeout
    );

    modport slave (
        output req, req_rate, req_pclk_rate, req_width, active_lanes,
        output PclkChangeOk, PhyStatus,
        input  Rate, PCLKRate, width, PclkChangeAck, busy, tx_hold, done, timeout
    );
endinterface

// File: rtl/pipe_rate_change_ctrl.sv
// MAC-side sequencer for the PIPE Rate/PCLKRate/width change handshake with
// per-wait-state timeout, plus a small checker for output invariants.
module pipe_rate_change_ctrl #(
    parameter int         LANESNUMBER    = 16,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [1:0] RESET_WIDTH    = 2'b10
) (
    input  logic              PCLK,
    input  logic              rst_n,
    pipe_rate_change_if.master bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [LANESNUMBER-1:0] LANES_ZERO = {LANESNUMBER{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_OK = 2'd1,
        WAIT_PS = 2'd2
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [3:0]             rate_r, rate_nxt_s;
    logic [4:0]             pclk_rate_r, pclk_rate_nxt_s;
    logic [1:0]             width_r, width_nxt_s;
    logic                   ack_r, ack_nxt_s;
    logic                   busy_r, busy_nxt_s;
    logic                   done_r, done_nxt_s;
    logic                   timeout_r, timeout_nxt_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    logic [LANESNUMBER-1:0] mask_r, mask_nxt_s;
    logic [LANESNUMBER-1:0] sticky_r, sticky_nxt_s;

    logic                   same_target_s;
    logic [LANESNUMBER-1:0] ps_hit_s;
    logic                   all_seen_s;
    logic                   cnt_max_s;

    assign same_target_s = ({bus.req_rate, bus.req_pclk_rate, bus.req_width} ==
                            {rate_r, pclk_rate_r, width_r});
    // Lanes completing on this very edge count, so a single-cycle PhyStatus suffices.
    assign ps_hit_s   = bus.PhyStatus & mask_r;
    assign all_seen_s = ((sticky_r | ps_hit_s) == mask_r);
    assign cnt_max_s  = (cnt_r == CNT_MAX);

    // next-state and next-output decode
    always_comb begin
        state_nxt_s     = state_r;
        rate_nxt_s      = rate_r;
        pclk_rate_nxt_s = pclk_rate_r;
        width_nxt_s     = width_r;
        ack_nxt_s       = ack_r;
        done_nxt_s      = 1'b0;
        timeout_nxt_s   = 1'b0;
        cnt_nxt_s       = cnt_r;
        mask_nxt_s      = mask_r;
        sticky_nxt_s    = sticky_r;
        case (state_r)
            IDLE: begin
                ack_nxt_s = 1'b0;
                if (bus.req && same_target_s) begin
                    done_nxt_s = 1'b1;
                end else if (bus.req) begin
                    rate_nxt_s      = bus.req_rate;
                    pclk_rate_nxt_s = bus.req_pclk_rate;
                    width_nxt_s     = bus.req_width;
                    mask_nxt_s      = bus.active_lanes;
                    cnt_nxt_s       = CNT_ZERO;
                    state_nxt_s     = WAIT_OK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_OK: begin
                if (bus.PclkChangeOk) begin
                    state_nxt_s  = WAIT_PS;
                    ack_nxt_s    = 1'b1;
                    cnt_nxt_s    = CNT_ZERO;
                    sticky_nxt_s = LANES_ZERO;
                end else if (cnt_max_s) begin
                    state_nxt_s   = IDLE;
                    ack_nxt_s     = 1'b0;
                    timeout_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            WAIT_PS: begin
                // Exit is tested before the timeout so a coincident last PhyStatus wins.
                if (all_seen_s) begin
                    state_nxt_s  = IDLE;
                    ack_nxt_s    = 1'b0;
                    done_nxt_s   = 1'b1;
                    sticky_nxt_s = LANES_ZERO;
                end else if (cnt_max_s) begin
                    state_nxt_s   = IDLE;
                    ack_nxt_s     = 1'b0;
                    timeout_nxt_s = 1'b1;
                    sticky_nxt_s  = LANES_ZERO;
                end else begin
                    sticky_nxt_s = sticky_r | ps_hit_s;
                    cnt_nxt_s    = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                ack_nxt_s   = 1'b0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // state and registered outputs, synchronous active-low reset
    always_ff @(posedge PCLK) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rate_r      <= 4'd0;
            pclk_rate_r <= 5'd0;
            width_r     <= RESET_WIDTH;
            ack_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            cnt_r       <= CNT_ZERO;
            mask_r      <= LANES_ZERO;
            sticky_r    <= LANES_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            rate_r      <= rate_nxt_s;
            pclk_rate_r <= pclk_rate_nxt_s;
            width_r     <= width_nxt_s;
            ack_r       <= ack_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            timeout_r   <= timeout_nxt_s;
            cnt_r       <= cnt_nxt_s;
            mask_r      <= mask_nxt_s;
            sticky_r    <= sticky_nxt_s;
        end
    end

    assign bus.Rate          = rate_r;
    assign bus.PCLKRate      = pclk_rate_r;
    assign bus.width         = width_r;
    assign bus.PclkChangeAck = ack_r;
    assign bus.busy          = busy_r;
    assign bus.tx_hold       = busy_r;
    assign bus.done          = done_r;
    assign bus.timeout       = timeout_r;

    pipe_rate_change_ctrl_chk u_chk (
        .PCLK          (PCLK),
        .rst_n         (rst_n),
        .busy          (busy_r),
        .tx_hold       (busy_r),
        .PclkChangeAck (ack_r),
        .done          (done_r),
        .timeout       (timeout_r)
    );
endmodule

// Output invariants of the sequencer.
module pipe_rate_change_ctrl_chk (
    input logic PCLK,
    input logic rst_n,
    input logic busy,
    input logic tx_hold,
    input logic PclkChangeAck,
    input logic done,
    input logic timeout
);
    a_done_timeout_excl: assert property (@(posedge PCLK) disable iff (!rst_n) !(done && timeout));
    a_hold_eq_busy:      assert property (@(posedge PCLK) disable iff (!rst_n) tx_hold == busy);
    a_ack_only_busy:     assert property (@(posedge PCLK) disable iff (!rst_n) PclkChangeAck |-> busy);
endmodule

// File: doc/pipe_rate_change_ctrl.md
Name: pipe_rate_change_ctrl

Overview:
MAC-side sequencer for the PIPE rate / PCLK-rate / width change handshake. Accepts a single change request from the LTSSM and drives Rate, PCLKRate and width. Runs the PclkChangeOk → PclkChangeAck → per-lane PhyStatus handshake with a bounded timeout, and holds the TX datapath quiet for the whole change. Sits between the LTSSM and the PIPE interface signals.

Parameters:
LANESNUMBER, 16, number of lanes; width of PhyStatus and the lane mask.
TIMEOUT_CYCLES, 1024, maximum PCLK cycles spent in each wait state before abort (≥2); counter width = $clog2(TIMEOUT_CYCLES).
RESET_WIDTH, 2'b10, width value driven out of reset.

Ports:
PCLK  in  1  PIPE clock; all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
req  in  1  change request from LTSSM; sampled only in IDLE.
req_rate  in  4  target Rate.
req_pclk_rate  in  5  target PCLKRate.
req_width  in  2  target width.
active_lanes  in  LANESNUMBER  lanes whose PhyStatus must be seen; sampled with req.
PclkChangeOk  in  1  PHY ready for MAC to switch PCLK.
PhyStatus  in  LANESNUMBER  per-lane completion pulse.
Rate  out  4  PIPE Rate.
PCLKRate  out  5  PIPE PCLKRate.
width  out  2  PIPE width.
PclkChangeAck  out  1  MAC acknowledge of PCLK change.
busy  out  1  change in progress.
tx_hold  out  1  datapath must deassert TxDataValid and hold TxElecIdle; equals busy.
done  out  1  one-cycle pulse: change completed.
timeout  out  1  one-cycle pulse: change aborted.

Behaviour:
- Reset (rst_n=0 at an edge, any state): state=IDLE; Rate=0, PCLKRate=0, width=RESET_WIDTH; PclkChangeAck, busy, tx_hold, done, timeout=0; counter and sticky lane mask cleared. Reset mid-handshake drops PclkChangeAck on the next edge.
- All outputs are registered. busy = (state != IDLE).
- States: IDLE, WAIT_OK, WAIT_PS.
- IDLE with req=1 at edge k:
  - If the target {req_rate, req_pclk_rate, req_width} equals the current {Rate, PCLKRate, width}: no-op, stay IDLE, done=1 in cycle k+1.
  - Otherwise, from cycle k+1: Rate/PCLKRate/width take the target values, mask register = active_lanes, state=WAIT_OK, busy=tx_hold=1, counter=0.
- req while busy is ignored and not queued. Requester must re-issue after done/timeout.
- WAIT_OK: on an edge with PclkChangeOk=1, go to WAIT_PS from the next cycle with PclkChangeAck=1, counter=0, sticky mask cleared.
- WAIT_PS: sticky |= PhyStatus & mask each edge. When (sticky | (PhyStatus & mask)) == mask at edge n: from cycle n+1 PclkChangeAck=0, busy=tx_hold=0, done=1 for one cycle, state=IDLE.
  - mask==0 completes at the first WAIT_PS edge.
  - PhyStatus on unmasked lanes, or PhyStatus outside WAIT_PS, is ignored.
- Timeout: counter increments each cycle in WAIT_OK/WAIT_PS. If counter == TIMEOUT_CYCLES-1 at an edge and that state's exit condition is false: next cycle state=IDLE, PclkChangeAck=0, busy=0, timeout=1 for one cycle. Rate/PCLKRate/width keep the new values. If exit and timeout coincide, exit wins (done, not timeout).
- done and timeout are never high together, and are never high for two consecutive cycles from a single request.
- Counter saturates logically via the state exit; no wrap is ever observable.

Test Plan:
1. Normal Gen1→Gen3: req with rate=2, pclk=2, width=2'b10, active_lanes=16'hFFFF; PclkChangeOk 3 cycles later; PhyStatus on all lanes together 2 cycles after ack → Rate=2 one cycle after req, ack rises one cycle after Ok, ack falls and done=1 one cycle after PhyStatus, busy low for the same cycle.
2. Staggered PhyStatus: mask=16'h000F, PhyStatus pulses on lanes 0, 1, 2, 3 in separate cycles plus lane 8 noise → completion only on the cycle after lane 3; lane 8 has no effect.
3. No-op: req with target equal to current values → done=1 next cycle, busy never asserted, PclkChangeAck never asserted.
4. Timeout: TIMEOUT_CYCLES=8, PclkChangeOk held 0 → timeout=1 exactly 8 cycles after entering WAIT_OK; Rate keeps new value, ack stays 0. Repeat with Ok asserted and lane 5 PhyStatus withheld → timeout, ack drops.
5. Boundary coincidence: final PhyStatus arrives at counter==TIMEOUT_CYCLES-1 → done=1, timeout=0.
6. Reset mid-WAIT_PS plus busy req: second req while busy is ignored; rst_n=0 for one edge → next cycle Rate=0, width=2'b10, ack=0, busy=0, and no done/timeout pulse.
